tcp_conn_ctrl: RTL

Server-side TCP connection controller: sequences one passive-open connection through LISTEN, three-way handshake, established, and passive close. It consumes parsed RX segment headers, issues control segments (SYN-ACK, ACK, FIN-ACK) to the TX segment builder over a valid/ready handshake, and retransmits unacknowledged SYN-ACK/FIN on a cycle-count timeout. It sits between the RX header parser and the TX segment builder and configures both through its sequence-number state.

---
 rtl/tcp_conn_ctrl_if.sv | 30 +++
 rtl/tcp_conn_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/tcp_conn_ctrl_if.sv
// Connection-controller bus: RX header channel, TX control-segment channel,
// application controls and connection status.
interface tcp_conn_ctrl_if;
    logic        listen_en;
    logic        close_req;
    logic [31:0] isn;
    logic        rx_valid;
    logic        rx_ready;
    logic [3:0]  rx_flags;
    logic [31:0] rx_seq;
    logic [31:0] rx_ack;
    logic        tx_valid;
    logic        tx_ready;
    logic [3:0]  tx_flags;
    logic [31:0] tx_seq;
    logic [31:0] tx_ack;
    logic [2:0]  state;
    logic        established;
    logic        conn_abort;

    modport master (
        input  listen_en, close_req, isn, rx_valid, rx_flags, rx_seq, rx_ack, tx_ready,
        output rx_ready, tx_valid, tx_flags, tx_seq, tx_ack, state, established, conn_abort
    );

    modport slave (
        output listen_en, close_req, isn, rx_valid, rx_flags, rx_seq, rx_ack, tx_ready,
        input  rx_ready, tx_valid, tx_flags, tx_seq, tx_ack, state, established, conn_abort
    );
endinterface

// File: rtl/tcp_conn_ctrl.sv
// Server-side TCP connection controller: passive open, handshake, established,
// passive close, with timed retransmission of SYN-ACK and FIN-ACK.
module tcp_conn_ctrl #(
    parameter int unsigned RTO_CYCLES  = 1024,
    parameter int unsigned MAX_RETRIES = 3
) (
    input logic            clk,
    input logic            rst,
    tcp_conn_ctrl_if.master bus
);
    localparam int TW = $clog2(RTO_CYCLES);
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [TW-1:0] TIMER_MAX = TW'(RTO_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

    localparam logic [3:0] FLG_SYNACK = 4'b0110;
    localparam logic [3:0] FLG_ACK    = 4'b0010;
    localparam logic [3:0] FLG_FINACK = 4'b0011;

    typedef enum logic [2:0] {
        ST_CLOSED      = 3'd0,
        ST_LISTEN      = 3'd1,
        ST_SYN_RCVD    = 3'd2,
        ST_ESTABLISHED = 3'd3,
        ST_CLOSE_WAIT  = 3'd4,
        ST_LAST_ACK    = 3'd5
    } state_e;

    state_e        state_q, state_d;
    logic          tx_valid_q, tx_valid_d;
    logic [3:0]    tx_flags_q, tx_flags_d;
    logic [31:0]   tx_seq_q, tx_seq_d;
    logic [31:0]   tx_ack_q, tx_ack_d;
    logic [31:0]   snd_nxt_q, snd_nxt_d;
    logic [31:0]   rcv_nxt_q, rcv_nxt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          abort_q, abort_d;

    logic rx_fire, tx_fire, waiting, expire, go_idle;
    logic ev_rst, ev_syn, ev_fin, ev_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_CLOSED;
            tx_valid_q <= 1'b0;
            tx_flags_q <= '0;
            tx_seq_q   <= '0;
            tx_ack_q   <= '0;
            snd_nxt_q  <= '0;
            rcv_nxt_q  <= '0;
            timer_q    <= '0;
            retry_q    <= '0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_valid_q <= tx_valid_d;
            tx_flags_q <= tx_flags_d;
            tx_seq_q   <= tx_seq_d;
            tx_ack_q   <= tx_ack_d;
            snd_nxt_q  <= snd_nxt_d;
            rcv_nxt_q  <= rcv_nxt_d;
            timer_q    <= timer_d;
            retry_q    <= retry_d;
            abort_q    <= abort_d;
        end
    end

    // Each segment is classified by its highest-priority flag: rst > syn > fin > ack.
    always_comb begin
        rx_fire = bus.rx_valid && !tx_valid_q;
        tx_fire = tx_valid_q && bus.tx_ready;
        waiting = (state_q == ST_SYN_RCVD) || (state_q == ST_LAST_ACK);
        expire  = waiting && !tx_valid_q && (timer_q == TIMER_MAX) && !rx_fire;
        ev_rst  = rx_fire && bus.rx_flags[3];
        ev_syn  = rx_fire && (bus.rx_flags[3:2] == 2'b01);
        ev_fin  = rx_fire && (bus.rx_flags[3:2] == 2'b00) && bus.rx_flags[0];
        ev_ack  = rx_fire && (bus.rx_flags[3:2] == 2'b00) && !bus.rx_flags[0] && bus.rx_flags[1];

        state_d    = state_q;
        tx_valid_d = tx_valid_q && !bus.tx_ready;
        tx_flags_d = tx_flags_q;
        tx_seq_d   = tx_seq_q;
        tx_ack_d   = tx_ack_q;
        snd_nxt_d  = snd_nxt_q;
        rcv_nxt_d  = rcv_nxt_q;
        retry_d    = retry_q;
        abort_d    = 1'b0;
        go_idle    = 1'b0;
        timer_d    = timer_q;

        // Timer saturates at expiry so an RX segment winning the cycle defers it.
        if (tx_fire) begin
            timer_d = '0;
        end else if (waiting && !tx_valid_q && (timer_q != TIMER_MAX)) begin
            timer_d = timer_q + 1'b1;
        end

        case (state_q)
            ST_CLOSED: begin
                if (bus.listen_en) state_d = ST_LISTEN;
            end
            ST_LISTEN: begin
                if (!bus.listen_en) begin
                    state_d = ST_CLOSED;
                    go_idle = 1'b1;
                end else if (ev_syn && !bus.rx_flags[1]) begin
                    rcv_nxt_d  = bus.rx_seq + 32'd1;
                    snd_nxt_d  = bus.isn + 32'd1;
                    tx_valid_d = 1'b1;
                    tx_flags_d = FLG_SYNACK;
                    tx_seq_d   = bus.isn;
                    tx_ack_d   = bus.rx_seq + 32'd1;
                    retry_d    = '0;
                    timer_d    = '0;
                    state_d    = ST_SYN_RCVD;
                end
            end
            ST_SYN_RCVD, ST_LAST_ACK: begin
                if (ev_rst) begin
                    abort_d = 1'b1;
                    state_d = ST_LISTEN;
                    go_idle = 1'b1;
                end else if (state_q == ST_SYN_RCVD && ev_ack &&
                             bus.rx_ack == snd_nxt_q && bus.rx_seq == rcv_nxt_q) begin
                    state_d = ST_ESTABLISHED;
                end else if (state_q == ST_LAST_ACK && ev_ack && bus.rx_ack == snd_nxt_q) begin
                    state_d = bus.listen_en ? ST_LISTEN : ST_CLOSED;
                    go_idle = 1'b1;
                end else if (expire) begin
                    if (retry_q == RETRY_MAX) begin
                        abort_d = 1'b1;
                        state_d = ST_LISTEN;
                        go_idle = 1'b1;
                    end else begin
                        tx_valid_d = 1'b1;
                        tx_flags_d = (state_q == ST_SYN_RCVD) ? FLG_SYNACK : FLG_FINACK;
                        tx_seq_d   = snd_nxt_q - 32'd1;
                        tx_ack_d   = rcv_nxt_q;
                        retry_d    = retry_q + 1'b1;
                        timer_d    = '0;
                    end
                end
            end
            ST_ESTABLISHED: begin
                if (ev_rst) begin
                    abort_d = 1'b1;
                    state_d = ST_LISTEN;
                    go_idle = 1'b1;
                end else if (ev_fin && bus.rx_seq == rcv_nxt_q) begin
                    rcv_nxt_d  = rcv_nxt_q + 32'd1;
                    tx_valid_d = 1'b1;
                    tx_flags_d = FLG_ACK;
                    tx_seq_d   = snd_nxt_q;
                    tx_ack_d   = bus.rx_seq + 32'd1;
                    timer_d    = '0;
                    state_d    = ST_CLOSE_WAIT;
                end
            end
            ST_CLOSE_WAIT: begin
                if (ev_rst) begin
                    abort_d = 1'b1;
                    state_d = ST_LISTEN;
                    go_idle = 1'b1;
                end else if (bus.close_req && !tx_valid_q) begin
                    tx_valid_d = 1'b1;
                    tx_flags_d = FLG_FINACK;
                    tx_seq_d   = snd_nxt_q;
                    tx_ack_d   = rcv_nxt_q;
                    snd_nxt_d  = snd_nxt_q + 32'd1;
                    retry_d    = '0;
                    timer_d    = '0;
                    state_d    = ST_LAST_ACK;
                end
            end
            default: state_d = ST_CLOSED;
        endcase

        // A pending control segment survives the drop back to LISTEN/CLOSED.
        if (go_idle) begin
            snd_nxt_d = '0;
            rcv_nxt_d = '0;
            retry_d   = '0;
            timer_d   = '0;
        end
    end

    always_comb begin
        bus.rx_ready    = !tx_valid_q;
        bus.tx_valid    = tx_valid_q;
        bus.tx_flags    = tx_flags_q;
        bus.tx_seq      = tx_seq_q;
        bus.tx_ack      = tx_ack_q;
        bus.state       = state_q;
        bus.established = (state_q == ST_ESTABLISHED);
        bus.conn_abort  = abort_q;
    end
endmodule
